// File: rtl/ring_fifo.sv
// Circular-buffer FIFO with a registered output stage, occupancy flags and synchronous flush.
// Define RING_FIFO_DROP_EN to never stall the producer and drop words that arrive while full.
module ring_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 16,
  parameter int AFULL      = DEPTH - 2,
  parameter int AEMPTY     = 1,
  parameter int SIZE_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  flush,
  output logic [SIZE_WIDTH-1:0] size,
  output logic                  almost_full,
  output logic                  almost_empty,
  input  logic [WIDTH-1:0]      idata,
  input  logic                  ivalid,
  output logic                  iready,
  output logic [WIDTH-1:0]      odata,
  output logic                  ovalid,
  input  logic                  oready,
  output logic [7:0]            drop_count
);
  localparam int MEM_D = DEPTH - 1;
  localparam int PTR_W = (MEM_D > 1) ? $clog2(MEM_D) : 1;
  localparam logic [PTR_W-1:0]      PTR_LAST = PTR_W'(MEM_D - 1);
  localparam logic [SIZE_WIDTH-1:0] DEPTH_S  = SIZE_WIDTH'(DEPTH);
  localparam logic [SIZE_WIDTH-1:0] AFULL_S  = SIZE_WIDTH'(AFULL);
  localparam logic [SIZE_WIDTH-1:0] AEMPTY_S = SIZE_WIDTH'(AEMPTY);
  localparam logic [SIZE_WIDTH-1:0] ONE_S    = SIZE_WIDTH'(1);
  localparam logic                  AF_RST   = (AFULL == 0);

  logic [SIZE_WIDTH-1:0] r_size, w_next;
  logic                  r_ovalid, r_afull, r_aempty;
  logic [WIDTH-1:0]      r_odata;
  logic [WIDTH-1:0]      r_mem [MEM_D];
  logic [PTR_W-1:0]      r_wptr, r_rptr;
  logic                  w_itx, w_otx, w_mem_empty, w_bypass, w_mem_wr, w_mem_rd;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_otx = r_ovalid && oready;

`ifdef RING_FIFO_DROP_EN
  logic       w_drop;
  logic [7:0] r_drop;

  // Accept whenever a slot exists after this cycle's read; otherwise the word is lost.
  assign w_itx      = ivalid && ((r_size != DEPTH_S) || w_otx);
  assign w_drop     = ivalid && !w_itx;
  assign iready     = 1'b1;
  assign drop_count = r_drop;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)                        r_drop <= '0;
    else if (w_drop && r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
  end
`else
  logic r_iready;

  assign w_itx      = ivalid && r_iready;
  assign iready     = r_iready;
  assign drop_count = '0;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)    r_iready <= 1'b0;
    else if (flush) r_iready <= 1'b1;
    else            r_iready <= (w_next < DEPTH_S);
  end
`endif

  assign w_next      = r_size - SIZE_WIDTH'(w_otx) + SIZE_WIDTH'(w_itx);
  assign w_mem_empty = (r_size <= ONE_S);
  // Incoming word goes straight to the output register when nothing is queued ahead of it.
  assign w_bypass    = w_itx && (!r_ovalid || (w_otx && w_mem_empty));
  assign w_mem_wr    = w_itx && !w_bypass && !flush;
  assign w_mem_rd    = w_otx && !w_mem_empty;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_size   <= '0;
      r_ovalid <= 1'b0;
      r_afull  <= AF_RST;
      r_aempty <= 1'b1;
      r_wptr   <= '0;
      r_rptr   <= '0;
    end else if (flush) begin
      r_size   <= '0;
      r_ovalid <= 1'b0;
      r_afull  <= AF_RST;
      r_aempty <= 1'b1;
      r_wptr   <= '0;
      r_rptr   <= '0;
    end else begin
      r_size   <= w_next;
      r_ovalid <= (w_next != '0);
      r_afull  <= (w_next >= AFULL_S);
      r_aempty <= (w_next <= AEMPTY_S);
      if (w_mem_wr) r_wptr <= ptr_inc(r_wptr);
      if (w_mem_rd) r_rptr <= ptr_inc(r_rptr);
    end
  end

  // Data path carries no reset; contents are meaningless while ovalid is low.
  always_ff @(posedge clock) begin
    if (w_mem_wr) r_mem[r_wptr] <= idata;
    if (!flush) begin
      if (w_mem_rd)      r_odata <= r_mem[r_rptr];
      else if (w_bypass) r_odata <= idata;
    end
  end

  assign size         = r_size;
  assign almost_full  = r_afull;
  assign almost_empty = r_aempty;
  assign odata        = r_odata;
  assign ovalid       = r_ovalid;
endmodule

// File: tb/tb_ring_fifo.sv
// Directed bench for ring_fifo: four instances (DEPTH 16/5/7/4) share one stimulus set.
module tb_ring_fifo;
`ifdef RING_FIFO_DROP_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       resetn = 1'b1;
  logic       flush = 1'b0;
  logic [7:0] idata = '0;
  logic       ivalid = 1'b0;
  logic       oready = 1'b0;

  logic [4:0] size_16;
  logic [2:0] size_5, size_7, size_4;
  logic       af_16, ae_16, ir_16, ov_16;
  logic       af_5, ae_5, ir_5, ov_5;
  logic       af_7, ae_7, ir_7, ov_7;
  logic       af_4, ae_4, ir_4, ov_4;
  logic [7:0] od_16, od_5, od_7, od_4;
  logic [7:0] dc_16, dc_5, dc_7, dc_4;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  ring_fifo #(.WIDTH(8), .DEPTH(16)) u16 (
    .clock(clock), .resetn(resetn), .flush(flush), .size(size_16),
    .almost_full(af_16), .almost_empty(ae_16), .idata(idata), .ivalid(ivalid),
    .iready(ir_16), .odata(od_16), .ovalid(ov_16), .oready(oready), .drop_count(dc_16));
  ring_fifo #(.WIDTH(8), .DEPTH(5)) u5 (
    .clock(clock), .resetn(resetn), .flush(flush), .size(size_5),
    .almost_full(af_5), .almost_empty(ae_5), .idata(idata), .ivalid(ivalid),
    .iready(ir_5), .odata(od_5), .ovalid(ov_5), .oready(oready), .drop_count(dc_5));
  ring_fifo #(.WIDTH(8), .DEPTH(7)) u7 (
    .clock(clock), .resetn(resetn), .flush(flush), .size(size_7),
    .almost_full(af_7), .almost_empty(ae_7), .idata(idata), .ivalid(ivalid),
    .iready(ir_7), .odata(od_7), .ovalid(ov_7), .oready(oready), .drop_count(dc_7));
  ring_fifo #(.WIDTH(8), .DEPTH(4)) u4 (
    .clock(clock), .resetn(resetn), .flush(flush), .size(size_4),
    .almost_full(af_4), .almost_empty(ae_4), .idata(idata), .ivalid(ivalid),
    .iready(ir_4), .odata(od_4), .ovalid(ov_4), .oready(oready), .drop_count(dc_4));

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset;
    @(posedge clock);
    #1;
    ivalid = 1'b0; oready = 1'b0; flush = 1'b0;
    resetn = 1'b0;
    #3;
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    @(posedge clock);
    #1;
    ivalid = 1'b0; oready = 1'b0; flush = 1'b0;
    resetn = 1'b0;
    #2;
    checks++; if (size_16 !== 5'd0) begin errors++; $display("FAIL reset_size got %0d exp 0", size_16); end
    checks++; if (ov_16 !== 1'b0) begin errors++; $display("FAIL reset_ovalid got %b exp 0", ov_16); end
    checks++; if (ir_16 !== DROP) begin errors++; $display("FAIL reset_iready got %b exp %b", ir_16, DROP); end
    checks++; if (ae_16 !== 1'b1) begin errors++; $display("FAIL reset_aempty got %b exp 1", ae_16); end
    checks++; if (af_16 !== 1'b0) begin errors++; $display("FAIL reset_afull got %b exp 0", af_16); end
    checks++; if (dc_4 !== 8'd0) begin errors++; $display("FAIL reset_dropcnt got %0d exp 0", dc_4); end
    resetn = 1'b1;
    tick();
    checks++; if (ir_16 !== 1'b1) begin errors++; $display("FAIL post_reset_iready got %b exp 1", ir_16); end
    checks++; if (size_16 !== 5'd0) begin errors++; $display("FAIL post_reset_size got %0d exp 0", size_16); end
  endtask

  task automatic test_fill_drain;
    do_reset();
    ivalid = 1'b1; oready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      idata = 8'(i);
      tick();
      checks++; if (size_16 !== 5'(i + 1)) begin errors++; $display("FAIL fill_size[%0d] got %0d exp %0d", i, size_16, i + 1); end
      checks++; if (af_16 !== (i + 1 >= 14)) begin errors++; $display("FAIL fill_afull[%0d] got %b exp %b", i, af_16, (i + 1 >= 14)); end
      checks++; if (ae_16 !== (i + 1 <= 1)) begin errors++; $display("FAIL fill_aempty[%0d] got %b exp %b", i, ae_16, (i + 1 <= 1)); end
      checks++; if (ir_16 !== ((i + 1 < 16) || DROP)) begin errors++; $display("FAIL fill_iready[%0d] got %b exp %b", i, ir_16, ((i + 1 < 16) || DROP)); end
      checks++; if (od_16 !== 8'h00 || ov_16 !== 1'b1) begin errors++; $display("FAIL fill_head[%0d] got %h/%b exp 00/1", i, od_16, ov_16); end
    end
    ivalid = 1'b0; oready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checks++; if (ov_16 !== 1'b1 || od_16 !== 8'(i)) begin errors++; $display("FAIL drain_data[%0d] got %h/%b exp %h/1", i, od_16, ov_16, 8'(i)); end
      tick();
      checks++; if (size_16 !== 5'(15 - i)) begin errors++; $display("FAIL drain_size[%0d] got %0d exp %0d", i, size_16, 15 - i); end
      checks++; if (ir_16 !== 1'b1) begin errors++; $display("FAIL drain_iready[%0d] got %b exp 1", i, ir_16); end
    end
    checks++; if (ov_16 !== 1'b0) begin errors++; $display("FAIL drain_ovalid_end got %b exp 0", ov_16); end
    checks++; if (ae_16 !== 1'b1) begin errors++; $display("FAIL drain_aempty_end got %b exp 1", ae_16); end
    oready = 1'b0;
  endtask

  task automatic test_single;
    do_reset();
    checks++; if (ov_16 !== 1'b0) begin errors++; $display("FAIL single_pre_ovalid got %b exp 0", ov_16); end
    ivalid = 1'b1; idata = 8'hA5;
    tick();
    ivalid = 1'b0;
    checks++; if (ov_16 !== 1'b1 || od_16 !== 8'hA5) begin errors++; $display("FAIL single_out got %h/%b exp a5/1", od_16, ov_16); end
    checks++; if (size_16 !== 5'd1) begin errors++; $display("FAIL single_size got %0d exp 1", size_16); end
    tick();
    checks++; if (od_16 !== 8'hA5 || ov_16 !== 1'b1) begin errors++; $display("FAIL single_hold got %h/%b exp a5/1", od_16, ov_16); end
  endtask

  task automatic test_back_to_back;
    do_reset();
    ivalid = 1'b1; oready = 1'b1; idata = 8'd0;
    tick();
    for (int k = 1; k <= 100; k++) begin
      idata = 8'(k);
      tick();
      checks++; if (ov_5 !== 1'b1 || od_5 !== 8'(k)) begin errors++; $display("FAIL b2b_data[%0d] got %h/%b exp %h/1", k, od_5, ov_5, 8'(k)); end
      checks++; if (size_5 !== 3'd1) begin errors++; $display("FAIL b2b_size[%0d] got %0d exp 1", k, size_5); end
    end
    // Deep variant keeps three words queued so the ring pointers wrap many times.
    do_reset();
    ivalid = 1'b1; oready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      idata = 8'(k);
      tick();
    end
    oready = 1'b1;
    for (int k = 3; k < 43; k++) begin
      idata = 8'(k);
      tick();
      checks++; if (od_5 !== 8'(k - 2)) begin errors++; $display("FAIL wrap_data[%0d] got %h exp %h", k, od_5, 8'(k - 2)); end
      checks++; if (size_5 !== 3'd3) begin errors++; $display("FAIL wrap_size[%0d] got %0d exp 3", k, size_5); end
    end
    ivalid = 1'b0;
    for (int k = 43; k < 45; k++) begin
      tick();
      checks++; if (od_5 !== 8'(k - 2)) begin errors++; $display("FAIL wrap_tail[%0d] got %h exp %h", k, od_5, 8'(k - 2)); end
    end
    oready = 1'b0;
  endtask

  task automatic test_flush;
    do_reset();
    ivalid = 1'b1; oready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      idata = 8'(8'h10 + i);
      tick();
    end
    checks++; if (size_16 !== 5'd10) begin errors++; $display("FAIL flush_pre_size got %0d exp 10", size_16); end
    flush = 1'b1; idata = 8'hEE;
    tick();
    flush = 1'b0; ivalid = 1'b0;
    checks++; if (size_16 !== 5'd0) begin errors++; $display("FAIL flush_size got %0d exp 0", size_16); end
    checks++; if (ov_16 !== 1'b0) begin errors++; $display("FAIL flush_ovalid got %b exp 0", ov_16); end
    checks++; if (ir_16 !== 1'b1) begin errors++; $display("FAIL flush_iready got %b exp 1", ir_16); end
    checks++; if (ae_16 !== 1'b1 || af_16 !== 1'b0) begin errors++; $display("FAIL flush_flags got af=%b ae=%b exp 0/1", af_16, ae_16); end
    ivalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idata = 8'(8'h30 + i);
      tick();
    end
    ivalid = 1'b0; oready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (ov_16 !== 1'b1 || od_16 !== 8'(8'h30 + i)) begin errors++; $display("FAIL flush_after[%0d] got %h/%b exp %h/1", i, od_16, ov_16, 8'(8'h30 + i)); end
      tick();
    end
    checks++; if (ov_16 !== 1'b0) begin errors++; $display("FAIL flush_after_empty got %b exp 0", ov_16); end
    oready = 1'b0;
  endtask

  task automatic test_drop;
    do_reset();
    ivalid = 1'b1; oready = 1'b0;
    for (int i = 0; i < 300; i++) begin
      idata = 8'(i);
      tick();
      if (i == 9) begin
        checks++; if (dc_4 !== (DROP ? 8'd6 : 8'd0)) begin errors++; $display("FAIL drop_mid got %0d exp %0d", dc_4, DROP ? 6 : 0); end
      end
    end
    checks++; if (size_4 !== 3'd4) begin errors++; $display("FAIL drop_size got %0d exp 4", size_4); end
    checks++; if (ir_4 !== DROP) begin errors++; $display("FAIL drop_iready got %b exp %b", ir_4, DROP); end
    checks++; if (dc_4 !== (DROP ? 8'd255 : 8'd0)) begin errors++; $display("FAIL drop_count got %0d exp %0d", dc_4, DROP ? 255 : 0); end
    checks++; if (af_4 !== 1'b1) begin errors++; $display("FAIL drop_afull got %b exp 1", af_4); end
    ivalid = 1'b0; oready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (ov_4 !== 1'b1 || od_4 !== 8'(i)) begin errors++; $display("FAIL drop_read[%0d] got %h/%b exp %h/1", i, od_4, ov_4, 8'(i)); end
      tick();
    end
    oready = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (dc_4 !== (DROP ? 8'd255 : 8'd0)) begin errors++; $display("FAIL drop_after_flush got %0d exp %0d", dc_4, DROP ? 255 : 0); end
  endtask

  task automatic test_random;
    logic [7:0] q[$];
    bit itx, otx;
    int n;
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      n = q.size();
      checks++; if (size_7 !== 3'(n)) begin errors++; $display("FAIL rnd_size[%0d] got %0d exp %0d", c, size_7, n); end
      checks++; if (ov_7 !== (n > 0)) begin errors++; $display("FAIL rnd_ovalid[%0d] got %b exp %b", c, ov_7, (n > 0)); end
      checks++; if (ir_7 !== ((n < 7) || DROP)) begin errors++; $display("FAIL rnd_iready[%0d] got %b exp %b", c, ir_7, ((n < 7) || DROP)); end
      checks++; if (af_7 !== (n >= 5) || ae_7 !== (n <= 1)) begin errors++; $display("FAIL rnd_flags[%0d] got af=%b ae=%b n=%0d", c, af_7, ae_7, n); end
      if (n > 0) begin
        checks++; if (od_7 !== q[0]) begin errors++; $display("FAIL rnd_data[%0d] got %h exp %h", c, od_7, q[0]); end
      end
      ivalid = 1'($urandom_range(0, 1));
      oready = ($urandom_range(0, 3) != 0) ? (c % 300 < 150) : 1'($urandom_range(0, 1));
      idata  = 8'($urandom);
      otx = (n > 0) && oready;
      itx = ivalid && ((n < 7) || (DROP && otx));
      tick();
      if (otx) void'(q.pop_front());
      if (itx) q.push_back(idata);
    end
    ivalid = 1'b0; oready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_single();
    test_back_to_back();
    test_flush();
    test_drop();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
